// File: rtl/map_table_ckpt_if.sv
// Rename-stage bus of the checkpointed map table: source lookups, destination
// renames, CDB ready broadcasts and the checkpoint take/free/recover controls.
interface map_table_ckpt_if #(
  parameter int NUM_AREGS = 32,
  parameter int NUM_PREGS = 64,
  parameter int WAYS      = 2,
  parameter int CDB_WIDTH = 2,
  parameter int NUM_CKPT  = 4
);
  localparam int PW = $clog2(NUM_PREGS);
  localparam int AW = $clog2(NUM_AREGS);
  localparam int CW = $clog2(NUM_CKPT);

  logic [WAYS-1:0][AW-1:0]      src1_areg;
  logic [WAYS-1:0][AW-1:0]      src2_areg;
  logic [WAYS-1:0][PW-1:0]      src1_preg;
  logic [WAYS-1:0][PW-1:0]      src2_preg;
  logic [WAYS-1:0]              src1_ready;
  logic [WAYS-1:0]              src2_ready;
  logic [WAYS-1:0]              dest_valid;
  logic [WAYS-1:0][AW-1:0]      dest_areg;
  logic [WAYS-1:0][PW-1:0]      dest_new_preg;
  logic [WAYS-1:0][PW-1:0]      dest_old_preg;
  logic [CDB_WIDTH-1:0]         cdb_valid;
  logic [CDB_WIDTH-1:0][PW-1:0] cdb_preg;
  logic                         ckpt_take;
  logic                         ckpt_grant;
  logic [CW-1:0]                ckpt_grant_id;
  logic                         ckpt_free;
  logic [CW-1:0]                ckpt_free_id;
  logic                         recover;
  logic [CW-1:0]                recover_id;
  logic                         ckpt_full;

  // Rename/dispatch side drives requests and consumes mappings.
  modport master (
    output src1_areg, src2_areg, dest_valid, dest_areg, dest_new_preg,
           cdb_valid, cdb_preg, ckpt_take, ckpt_free, ckpt_free_id,
           recover, recover_id,
    input  src1_preg, src2_preg, src1_ready, src2_ready, dest_old_preg,
           ckpt_grant, ckpt_grant_id, ckpt_full
  );

  // Map table side.
  modport slave (
    input  src1_areg, src2_areg, dest_valid, dest_areg, dest_new_preg,
           cdb_valid, cdb_preg, ckpt_take, ckpt_free, ckpt_free_id,
           recover, recover_id,
    output src1_preg, src2_preg, src1_ready, src2_ready, dest_old_preg,
           ckpt_grant, ckpt_grant_id, ckpt_full
  );
endinterface

// File: rtl/map_table_ckpt.sv
// Superscalar register-rename map table with whole-table branch checkpoints.
// Each entry holds {preg, ready}; areg 0 is the hard-wired zero register.
module map_table_ckpt #(
  parameter int NUM_AREGS = 32,
  parameter int NUM_PREGS = 64,
  parameter int WAYS      = 2,
  parameter int CDB_WIDTH = 2,
  parameter int NUM_CKPT  = 4
) (
  input  logic             clk_i,
  input  logic             rst_i,
  map_table_ckpt_if.slave  bus
);
  localparam int PW = $clog2(NUM_PREGS);
  localparam int AW = $clog2(NUM_AREGS);
  localparam int CW = $clog2(NUM_CKPT);

  typedef struct packed {
    logic [PW-1:0] preg;
    logic          rdy;
  } entry_t;

  entry_t              tbl_q  [NUM_AREGS];
  entry_t              tbl_d  [NUM_AREGS];
  entry_t              snap_q [NUM_CKPT][NUM_AREGS];
  entry_t              snap_d [NUM_CKPT][NUM_AREGS];
  logic [NUM_CKPT-1:0] snap_vld_q;
  logic [NUM_CKPT-1:0] snap_vld_d;
  logic                rec_ok;
  logic                take_ok;
  logic [CW-1:0]       take_id;

  // Local copies of the broadcast/rename inputs used inside the helpers.
  logic [CDB_WIDTH-1:0]         cdb_valid;
  logic [CDB_WIDTH-1:0][PW-1:0] cdb_preg;
  logic [WAYS-1:0]              dest_valid;
  logic [WAYS-1:0][AW-1:0]      dest_areg;
  logic [WAYS-1:0][PW-1:0]      dest_new_preg;

  assign cdb_valid     = bus.cdb_valid;
  assign cdb_preg      = bus.cdb_preg;
  assign dest_valid    = bus.dest_valid;
  assign dest_areg     = bus.dest_areg;
  assign dest_new_preg = bus.dest_new_preg;

  // True when any valid CDB lane announces preg p this cycle.
  function automatic logic cdb_hit(input logic [PW-1:0] p);
    logic hit;
    hit = 1'b0;
    for (int c = 0; c < CDB_WIDTH; c++)
      if (cdb_valid[c] && cdb_preg[c] == p) hit = 1'b1;
    return hit;
  endfunction

  // Mapping seen by way `way`: table + CDB forward, overridden by the youngest older-way rename.
  function automatic entry_t lookup(input logic [AW-1:0] areg, input int way);
    entry_t e;
    e     = tbl_q[areg];
    e.rdy = e.rdy | cdb_hit(e.preg);
    for (int k = 0; k < WAYS; k++)
      if (k < way && dest_valid[k] && dest_areg[k] == areg) begin
        e.preg = dest_new_preg[k];
        e.rdy  = 1'b0;
      end
    if (areg == '0) begin
      e.preg = '0;
      e.rdy  = 1'b1;
    end
    return e;
  endfunction

  // Combinational per-way source and old-destination lookups.
  always_comb begin
    entry_t e1, e2, eo;
    for (int j = 0; j < WAYS; j++) begin
      e1 = lookup(bus.src1_areg[j], j);
      e2 = lookup(bus.src2_areg[j], j);
      eo = lookup(bus.dest_areg[j], j);
      bus.src1_preg[j]     = e1.preg;
      bus.src1_ready[j]    = e1.rdy;
      bus.src2_preg[j]     = e2.preg;
      bus.src2_ready[j]    = e2.rdy;
      bus.dest_old_preg[j] = eo.preg;
    end
  end

  // Table next state: restored snapshot on a valid recover, otherwise renames over CDB updates.
  always_comb begin
    rec_ok = bus.recover && snap_vld_q[bus.recover_id];
    for (int i = 0; i < NUM_AREGS; i++) begin
      tbl_d[i]     = rec_ok ? snap_q[bus.recover_id][i] : tbl_q[i];
      tbl_d[i].rdy = tbl_d[i].rdy | cdb_hit(tbl_d[i].preg);
    end
    // Ascending order lets the highest way win, and a rename overrides a same-cycle CDB hit.
    if (!rec_ok)
      for (int j = 0; j < WAYS; j++)
        if (dest_valid[j] && dest_areg[j] != '0)
          tbl_d[dest_areg[j]] = '{preg: dest_new_preg[j], rdy: 1'b0};
  end

  // Checkpoint allocation, release and snapshot next state.
  always_comb begin
    // NOTE: every always_comb output gets a default before any branch so no latch is inferred.
    take_ok = 1'b0;
    take_id = '0;
    // Descending scan so the lowest-index free slot is the last one written.
    if (bus.ckpt_take && !bus.recover)
      for (int s = NUM_CKPT - 1; s >= 0; s--)
        if (!snap_vld_q[s]) begin
          take_ok = 1'b1;
          take_id = CW'(s);
        end

    snap_vld_d = snap_vld_q;
    if (bus.ckpt_free) snap_vld_d[bus.ckpt_free_id] = 1'b0;
    if (rec_ok)        snap_vld_d[bus.recover_id]   = 1'b0;
    if (take_ok)       snap_vld_d[take_id]          = 1'b1;

    for (int s = 0; s < NUM_CKPT; s++)
      for (int i = 0; i < NUM_AREGS; i++) begin
        snap_d[s][i]     = snap_q[s][i];
        snap_d[s][i].rdy = snap_q[s][i].rdy | cdb_hit(snap_q[s][i].preg);
        if (take_ok && take_id == CW'(s)) snap_d[s][i] = tbl_d[i];
      end
  end

  assign bus.ckpt_grant    = take_ok;
  assign bus.ckpt_grant_id = take_id;
  assign bus.ckpt_full     = &snap_vld_q;

  // Table and slot-valid registers; reset restores identity mapping and frees all slots.
  always_ff @(posedge clk_i or posedge rst_i) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    if (rst_i) begin
      for (int i = 0; i < NUM_AREGS; i++) tbl_q[i] <= '{preg: PW'(i), rdy: 1'b1};
      snap_vld_q <= '0;
    end else begin
      tbl_q      <= tbl_d;
      snap_vld_q <= snap_vld_d;
    end
  end

  // Snapshot payload storage.
  always_ff @(posedge clk_i) begin
    // NOTE: payload is deliberately not reset; snap_vld_q guards every use of it.
    snap_q <= snap_d;
  end
endmodule

// File: tb/tb_map_table_ckpt.sv
// Self-checking bench for map_table_ckpt: directed scenarios plus randomized
// traffic compared against a sequential program-order reference model.
module tb_map_table_ckpt;
  localparam int NA = 32, NP = 64, WAYS = 2, CDBW = 2, NC = 4;
  localparam int PW = $clog2(NP), AW = $clog2(NA), CW = $clog2(NC);

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  map_table_ckpt_if #(.NUM_AREGS(NA), .NUM_PREGS(NP), .WAYS(WAYS),
                      .CDB_WIDTH(CDBW), .NUM_CKPT(NC)) bus ();

  map_table_ckpt #(.NUM_AREGS(NA), .NUM_PREGS(NP), .WAYS(WAYS),
                   .CDB_WIDTH(CDBW), .NUM_CKPT(NC)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus.slave)
  );

  // ---------------- reference model ----------------
  int m_preg [NA];  bit m_rdy [NA];
  int ck_preg[NC][NA]; bit ck_rdy[NC][NA]; bit ck_val[NC];
  int n_preg [NA];  bit n_rdy [NA];
  int n_ck_preg[NC][NA]; bit n_ck_rdy[NC][NA]; bit n_ck_val[NC];
  int e_s1p[WAYS], e_s2p[WAYS], e_old[WAYS];
  bit e_s1r[WAYS], e_s2r[WAYS];
  bit e_grant, e_full; int e_gid;

  function automatic bit hit(int p);
    for (int c = 0; c < CDBW; c++)
      if (bus.cdb_valid[c] && int'(bus.cdb_preg[c]) == p) return 1'b1;
    return 1'b0;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NA; i++) begin m_preg[i] = i; m_rdy[i] = 1'b1; end
    for (int s = 0; s < NC; s++) ck_val[s] = 1'b0;
  endtask

  // Instructions of the group are processed in program order against a working copy.
  task automatic model_eval();
    int cp[NA]; bit cr[NA]; int a, d, rid; bit rec_ok;
    for (int i = 0; i < NA; i++) begin cp[i] = m_preg[i]; cr[i] = m_rdy[i] | hit(m_preg[i]); end
    for (int j = 0; j < WAYS; j++) begin
      a = int'(bus.src1_areg[j]);
      e_s1p[j] = (a == 0) ? 0 : cp[a]; e_s1r[j] = (a == 0) ? 1'b1 : cr[a];
      a = int'(bus.src2_areg[j]);
      e_s2p[j] = (a == 0) ? 0 : cp[a]; e_s2r[j] = (a == 0) ? 1'b1 : cr[a];
      d = int'(bus.dest_areg[j]);
      e_old[j] = (d == 0) ? 0 : cp[d];
      if (bus.dest_valid[j] && d != 0) begin cp[d] = int'(bus.dest_new_preg[j]); cr[d] = 1'b0; end
    end
    rid = int'(bus.recover_id);
    rec_ok = bus.recover && ck_val[rid];
    for (int i = 0; i < NA; i++)
      if (rec_ok) begin n_preg[i] = ck_preg[rid][i]; n_rdy[i] = ck_rdy[rid][i] | hit(ck_preg[rid][i]); end
      else begin n_preg[i] = cp[i]; n_rdy[i] = cr[i]; end
    for (int s = 0; s < NC; s++) begin
      n_ck_val[s] = ck_val[s];
      for (int i = 0; i < NA; i++) begin
        n_ck_preg[s][i] = ck_preg[s][i];
        n_ck_rdy[s][i]  = ck_rdy[s][i] | hit(ck_preg[s][i]);
      end
    end
    e_grant = 1'b0; e_gid = 0;
    e_full = ck_val[0] && ck_val[1] && ck_val[2] && ck_val[3];
    if (bus.ckpt_take && !bus.recover)
      for (int s = 0; s < NC; s++)
        if (!ck_val[s] && !e_grant) begin e_grant = 1'b1; e_gid = s; end
    if (bus.ckpt_free) n_ck_val[int'(bus.ckpt_free_id)] = 1'b0;
    if (rec_ok) n_ck_val[rid] = 1'b0;
    if (e_grant) begin
      n_ck_val[e_gid] = 1'b1;
      for (int i = 0; i < NA; i++) begin n_ck_preg[e_gid][i] = n_preg[i]; n_ck_rdy[e_gid][i] = n_rdy[i]; end
    end
  endtask

  task automatic model_commit();
    m_preg = n_preg; m_rdy = n_rdy;
    ck_preg = n_ck_preg; ck_rdy = n_ck_rdy; ck_val = n_ck_val;
  endtask

  // ---------------- stimulus helpers ----------------
  task automatic drive_idle();
    bus.src1_areg = '0; bus.src2_areg = '0;
    bus.dest_valid = '0; bus.dest_areg = '0; bus.dest_new_preg = '0;
    bus.cdb_valid = '0; bus.cdb_preg = '0;
    bus.ckpt_take = 1'b0; bus.ckpt_free = 1'b0; bus.ckpt_free_id = '0;
    bus.recover = 1'b0; bus.recover_id = '0;
  endtask

  task automatic tick();
    model_eval();
    @(posedge clk);
    model_commit();
    @(negedge clk);
  endtask

  task automatic rename(int way, int areg, int preg);
    bus.dest_valid[way] = 1'b1;
    bus.dest_areg[way] = AW'(areg);
    bus.dest_new_preg[way] = PW'(preg);
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst = 1'b1; drive_idle();
    repeat (3) @(posedge clk);
    @(negedge clk); rst = 1'b0; model_reset();
    #1;
    checks++;
    if ({bus.ckpt_full, bus.ckpt_grant, bus.ckpt_grant_id} !== '0) begin
      errors++; $display("FAIL reset_ctrl: got %b want 0", {bus.ckpt_full, bus.ckpt_grant, bus.ckpt_grant_id});
    end
    for (int i = 0; i < NA; i++) begin
      bus.src1_areg[0] = AW'(i); bus.src2_areg[1] = AW'(i); #1;
      checks++;
      if ({bus.src1_preg[0], bus.src1_ready[0]} !== {PW'(i), 1'b1}) begin
        errors++; $display("FAIL reset_src1 areg %0d: got p%0d r%b want p%0d r1", i, bus.src1_preg[0], bus.src1_ready[0], i);
      end
      checks++;
      if ({bus.src2_preg[1], bus.src2_ready[1]} !== {PW'(i), 1'b1}) begin
        errors++; $display("FAIL reset_src2 areg %0d: got p%0d r%b want p%0d r1", i, bus.src2_preg[1], bus.src2_ready[1], i);
      end
    end
    drive_idle();
    @(negedge clk);
  endtask

  task automatic test_bypass();
    drive_idle();
    rename(0, 3, 40); rename(1, 3, 41);
    bus.src1_areg[1] = AW'(3); bus.src1_areg[0] = AW'(3); #1;
    checks++;
    if ({bus.src1_preg[1], bus.src1_ready[1]} !== {PW'(40), 1'b0}) begin
      errors++; $display("FAIL bypass_src: got p%0d r%b want p40 r0", bus.src1_preg[1], bus.src1_ready[1]);
    end
    checks++;
    if (bus.dest_old_preg[1] !== PW'(40)) begin
      errors++; $display("FAIL bypass_old1: got %0d want 40", bus.dest_old_preg[1]);
    end
    checks++;
    if (bus.dest_old_preg[0] !== PW'(3)) begin
      errors++; $display("FAIL bypass_old0: got %0d want 3", bus.dest_old_preg[0]);
    end
    checks++;
    if ({bus.src1_preg[0], bus.src1_ready[0]} !== {PW'(3), 1'b1}) begin
      errors++; $display("FAIL bypass_way0_src: got p%0d r%b want p3 r1", bus.src1_preg[0], bus.src1_ready[0]);
    end
    tick();
    drive_idle(); bus.src1_areg[0] = AW'(3); #1;
    checks++;
    if ({bus.src1_preg[0], bus.src1_ready[0]} !== {PW'(41), 1'b0}) begin
      errors++; $display("FAIL bypass_next: got p%0d r%b want p41 r0", bus.src1_preg[0], bus.src1_ready[0]);
    end
  endtask

  task automatic test_cdb();
    drive_idle(); rename(0, 5, 42); tick();
    drive_idle(); bus.src1_areg[0] = AW'(5);
    bus.cdb_valid[0] = 1'b1; bus.cdb_preg[0] = PW'(42); #1;
    checks++;
    if ({bus.src1_preg[0], bus.src1_ready[0]} !== {PW'(42), 1'b1}) begin
      errors++; $display("FAIL cdb_forward: got p%0d r%b want p42 r1", bus.src1_preg[0], bus.src1_ready[0]);
    end
    tick();
    drive_idle(); bus.src1_areg[0] = AW'(5); #1;
    checks++;
    if ({bus.src1_preg[0], bus.src1_ready[0]} !== {PW'(42), 1'b1}) begin
      errors++; $display("FAIL cdb_table: got p%0d r%b want p42 r1", bus.src1_preg[0], bus.src1_ready[0]);
    end
    rename(1, 6, 43); bus.cdb_valid[1] = 1'b1; bus.cdb_preg[1] = PW'(43);
    rename(0, 0, 55); #1;
    checks++;
    if (bus.dest_old_preg[0] !== PW'(0)) begin
      errors++; $display("FAIL zero_old: got %0d want 0", bus.dest_old_preg[0]);
    end
    tick();
    drive_idle(); bus.src1_areg[0] = AW'(6); bus.src2_areg[0] = AW'(0); #1;
    checks++;
    if ({bus.src1_preg[0], bus.src1_ready[0]} !== {PW'(43), 1'b0}) begin
      errors++; $display("FAIL rename_over_cdb: got p%0d r%b want p43 r0", bus.src1_preg[0], bus.src1_ready[0]);
    end
    checks++;
    if ({bus.src2_preg[0], bus.src2_ready[0]} !== {PW'(0), 1'b1}) begin
      errors++; $display("FAIL zero_write: got p%0d r%b want p0 r1", bus.src2_preg[0], bus.src2_ready[0]);
    end
  endtask

  task automatic test_ckpt_roundtrip();
    drive_idle(); rename(0, 7, 44); bus.ckpt_take = 1'b1; #1;
    checks++;
    if ({bus.ckpt_grant, bus.ckpt_grant_id} !== {1'b1, CW'(0)}) begin
      errors++; $display("FAIL take_first: got g%b id%0d want g1 id0", bus.ckpt_grant, bus.ckpt_grant_id);
    end
    tick();
    drive_idle(); rename(0, 7, 50); bus.cdb_valid[0] = 1'b1; bus.cdb_preg[0] = PW'(44); tick();
    drive_idle(); bus.src1_areg[0] = AW'(7); #1;
    checks++;
    if ({bus.src1_preg[0], bus.src1_ready[0]} !== {PW'(50), 1'b0}) begin
      errors++; $display("FAIL pre_recover: got p%0d r%b want p50 r0", bus.src1_preg[0], bus.src1_ready[0]);
    end
    bus.recover = 1'b1; bus.recover_id = CW'(0); rename(1, 8, 61); tick();
    drive_idle(); bus.src1_areg[0] = AW'(7); bus.src2_areg[0] = AW'(8); #1;
    checks++;
    if ({bus.src1_preg[0], bus.src1_ready[0]} !== {PW'(44), 1'b1}) begin
      errors++; $display("FAIL recover_entry: got p%0d r%b want p44 r1", bus.src1_preg[0], bus.src1_ready[0]);
    end
    checks++;
    if ({bus.src2_preg[0], bus.src2_ready[0]} !== {PW'(8), 1'b1}) begin
      errors++; $display("FAIL recover_drops_rename: got p%0d r%b want p8 r1", bus.src2_preg[0], bus.src2_ready[0]);
    end
  endtask

  task automatic test_full_free();
    for (int s = 0; s < NC; s++) begin
      drive_idle(); bus.ckpt_take = 1'b1; #1;
      checks++;
      if ({bus.ckpt_grant, bus.ckpt_grant_id} !== {1'b1, CW'(s)}) begin
        errors++; $display("FAIL take_seq %0d: got g%b id%0d want g1 id%0d", s, bus.ckpt_grant, bus.ckpt_grant_id, s);
      end
      tick();
    end
    drive_idle(); #1;
    checks++;
    if (bus.ckpt_full !== 1'b1) begin errors++; $display("FAIL full_set: got %b want 1", bus.ckpt_full); end
    bus.ckpt_take = 1'b1; #1;
    checks++;
    if (bus.ckpt_grant !== 1'b0) begin errors++; $display("FAIL take_when_full: got %b want 0", bus.ckpt_grant); end
    tick();
    drive_idle(); bus.ckpt_free = 1'b1; bus.ckpt_free_id = CW'(2); bus.ckpt_take = 1'b1; #1;
    checks++;
    if (bus.ckpt_grant !== 1'b0) begin errors++; $display("FAIL take_with_free: got %b want 0", bus.ckpt_grant); end
    tick();
    drive_idle(); #1;
    checks++;
    if (bus.ckpt_full !== 1'b0) begin errors++; $display("FAIL full_clear: got %b want 0", bus.ckpt_full); end
    bus.ckpt_take = 1'b1; #1;
    checks++;
    if ({bus.ckpt_grant, bus.ckpt_grant_id} !== {1'b1, CW'(2)}) begin
      errors++; $display("FAIL take_reuse: got g%b id%0d want g1 id2", bus.ckpt_grant, bus.ckpt_grant_id);
    end
    tick();
  endtask

  task automatic test_recover_invalid();
    drive_idle(); bus.ckpt_free = 1'b1; bus.ckpt_free_id = CW'(1); tick();
    drive_idle(); bus.recover = 1'b1; bus.recover_id = CW'(1); rename(0, 9, 60); tick();
    drive_idle(); bus.src1_areg[0] = AW'(9); bus.src2_areg[0] = AW'(7); #1;
    checks++;
    if ({bus.src1_preg[0], bus.src1_ready[0]} !== {PW'(60), 1'b0}) begin
      errors++; $display("FAIL bad_recover_rename: got p%0d r%b want p60 r0", bus.src1_preg[0], bus.src1_ready[0]);
    end
    checks++;
    if ({bus.src2_preg[0], bus.src2_ready[0]} !== {PW'(44), 1'b1}) begin
      errors++; $display("FAIL bad_recover_other: got p%0d r%b want p44 r1", bus.src2_preg[0], bus.src2_ready[0]);
    end
    checks++;
    if (bus.ckpt_full !== 1'b0) begin errors++; $display("FAIL bad_recover_full: got %b want 0", bus.ckpt_full); end
    bus.ckpt_take = 1'b1; #1;
    checks++;
    if ({bus.ckpt_grant, bus.ckpt_grant_id} !== {1'b1, CW'(1)}) begin
      errors++; $display("FAIL bad_recover_slots: got g%b id%0d want g1 id1", bus.ckpt_grant, bus.ckpt_grant_id);
    end
    tick();
  endtask

  task automatic test_random();
    for (int n = 0; n < 400; n++) begin
      drive_idle();
      for (int j = 0; j < WAYS; j++) begin
        bus.src1_areg[j] = AW'($urandom_range(0, 7));
        bus.src2_areg[j] = AW'($urandom_range(0, NA - 1));
        bus.dest_valid[j] = 1'($urandom_range(0, 1));
        bus.dest_areg[j] = AW'($urandom_range(0, 7));
        bus.dest_new_preg[j] = PW'($urandom_range(0, NP - 1));
      end
      for (int c = 0; c < CDBW; c++) begin
        bus.cdb_valid[c] = 1'($urandom_range(0, 1));
        bus.cdb_preg[c] = ($urandom_range(0, 1) == 1) ? PW'(m_preg[$urandom_range(0, 7)])
                                                      : PW'($urandom_range(0, NP - 1));
      end
      bus.ckpt_take = ($urandom_range(0, 2) == 0);
      bus.ckpt_free = ($urandom_range(0, 3) == 0);
      bus.ckpt_free_id = CW'($urandom_range(0, NC - 1));
      bus.recover = ($urandom_range(0, 5) == 0);
      bus.recover_id = CW'($urandom_range(0, NC - 1));
      #1;
      model_eval();
      for (int j = 0; j < WAYS; j++) begin
        checks++;
        if ({bus.src1_preg[j], bus.src1_ready[j]} !== {PW'(e_s1p[j]), e_s1r[j]}) begin
          errors++; $display("FAIL rand_src1 cyc %0d way %0d: got p%0d r%b want p%0d r%b", n, j, bus.src1_preg[j], bus.src1_ready[j], e_s1p[j], e_s1r[j]);
        end
        checks++;
        if ({bus.src2_preg[j], bus.src2_ready[j]} !== {PW'(e_s2p[j]), e_s2r[j]}) begin
          errors++; $display("FAIL rand_src2 cyc %0d way %0d: got p%0d r%b want p%0d r%b", n, j, bus.src2_preg[j], bus.src2_ready[j], e_s2p[j], e_s2r[j]);
        end
        checks++;
        if (bus.dest_old_preg[j] !== PW'(e_old[j])) begin
          errors++; $display("FAIL rand_old cyc %0d way %0d: got %0d want %0d", n, j, bus.dest_old_preg[j], e_old[j]);
        end
      end
      checks++;
      if (bus.ckpt_grant !== e_grant || (e_grant && bus.ckpt_grant_id !== CW'(e_gid))) begin
        errors++; $display("FAIL rand_grant cyc %0d: got g%b id%0d want g%b id%0d", n, bus.ckpt_grant, bus.ckpt_grant_id, e_grant, e_gid);
      end
      checks++;
      if (bus.ckpt_full !== e_full) begin
        errors++; $display("FAIL rand_full cyc %0d: got %b want %b", n, bus.ckpt_full, e_full);
      end
      tick();
    end
  endtask

  task automatic test_reset_midop();
    drive_idle(); rename(0, 2, 33); bus.ckpt_take = 1'b1; tick();
    drive_idle(); rename(0, 3, 34); bus.ckpt_take = 1'b1; tick();
    drive_idle(); bus.src1_areg[0] = AW'(2);
    #2 rst = 1'b1;
    #1;
    checks++;
    if (bus.ckpt_full !== 1'b0) begin errors++; $display("FAIL midreset_full: got %b want 0", bus.ckpt_full); end
    checks++;
    if ({bus.src1_preg[0], bus.src1_ready[0]} !== {PW'(2), 1'b1}) begin
      errors++; $display("FAIL midreset_table: got p%0d r%b want p2 r1", bus.src1_preg[0], bus.src1_ready[0]);
    end
    @(negedge clk); rst = 1'b0; model_reset();
    bus.ckpt_take = 1'b1; #1;
    checks++;
    if ({bus.ckpt_grant, bus.ckpt_grant_id} !== {1'b1, CW'(0)}) begin
      errors++; $display("FAIL midreset_slots: got g%b id%0d want g1 id0", bus.ckpt_grant, bus.ckpt_grant_id);
    end
    tick();
  endtask

  initial begin
    drive_idle();
    test_reset();
    test_bypass();
    test_cdb();
    test_ckpt_roundtrip();
    test_full_free();
    test_recover_invalid();
    test_random();
    test_reset_midop();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end
endmodule
